dreg_loader: RTL and testbench

DREG_LOADER -- requirements
Module: dreg_loader

---
 rtl/dreg_loader_pkg.sv | 16 +
 rtl/dreg_trig_pulse.sv | 46 ++++
 rtl/dreg_loader.sv | 142 ++++++++++++++
 tb/tb_dreg_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dreg_loader_pkg.sv
// Shared constants and state encoding for the data-register loader.
package dreg_loader_pkg;

   localparam int TOTAL_BITS_DFLT = 626;
   localparam int NBYTES_DFLT     = 79;
   localparam int TRIG_W_DFLT     = 4;
   localparam int CNT_W           = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_COMMIT = 2'd2,
      ST_FIRE   = 2'd3
   } state_e;

endpackage

// File: rtl/dreg_trig_pulse.sv
// Registered trigger pulse: while en is held, trig is high for TRIG_W cycles,
// starting one edge after en rises; done flags completion until en drops.
module dreg_trig_pulse
   import dreg_loader_pkg::*;
#(
   parameter int TRIG_W = TRIG_W_DFLT
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic en,
   output logic trig,
   output logic done
);

   localparam int CW = $clog2(TRIG_W + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          trig_q, trig_d;

   always_comb begin
      cnt_d  = '0;
      trig_d = 1'b0;
      if (en) begin
         if (cnt_q < CW'(TRIG_W)) begin
            cnt_d  = cnt_q + 1'b1;
            trig_d = 1'b1;
         end else begin
            cnt_d = cnt_q;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         trig_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         trig_q <= trig_d;
      end
   end

   assign trig = trig_q;
   assign done = (cnt_q == CW'(TRIG_W));

endmodule

// File: rtl/dreg_loader.sv
// Loads a byte-framed pattern into a shadow register, commits it to data_reg
// once the serializer is idle, and optionally fires a TRIG_W-cycle trigger.
module dreg_loader
   import dreg_loader_pkg::*;
#(
   parameter int TOTAL_BITS = TOTAL_BITS_DFLT,
   parameter int NBYTES     = NBYTES_DFLT,
   parameter int TRIG_W     = TRIG_W_DFLT
) (
   input  logic                  clk_in,
   input  logic                  rst_n,
   input  logic [7:0]            s_data,
   input  logic                  s_valid,
   input  logic                  s_sof,
   output logic                  s_ready,
   input  logic                  auto_trig,
   input  logic                  busy,
   output logic [TOTAL_BITS-1:0] data_reg,
   output logic                  trig,
   output logic                  frame_err,
   output logic                  committed
);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [TOTAL_BITS-1:0]   shadow_q, shadow_d;
   logic [TOTAL_BITS-1:0]   data_q, data_d;
   logic                    commit_q, commit_d;
   logic                    err_q, err_d;
   logic                    rdy_q, rdy_d;
   logic                    xfer;
   logic                    wr_en;
   logic [CNT_W-1:0]        wr_idx;
   logic                    pulse_en;
   logic                    pulse_done;

   assign xfer = s_valid && rdy_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      data_d   = data_q;
      commit_d = 1'b0;
      wr_en    = 1'b0;
      wr_idx   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               if (s_sof) begin
                  wr_en   = 1'b1;
                  wr_idx  = '0;
                  cnt_d   = CNT_W'(1);
                  state_d = ST_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            if (xfer) begin
               wr_en = 1'b1;
               if (s_sof) begin
                  // A new start-of-frame abandons the partial frame and begins again
                  err_d  = 1'b1;
                  wr_idx = '0;
                  cnt_d  = CNT_W'(1);
               end else if (cnt_q == CNT_W'(NBYTES - 1)) begin
                  cnt_d   = '0;
                  state_d = ST_COMMIT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_COMMIT: begin
            if (!busy) begin
               data_d   = shadow_q;
               commit_d = 1'b1;
               state_d  = auto_trig ? ST_FIRE : ST_IDLE;
            end
         end
         ST_FIRE: begin
            if (pulse_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      rdy_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
   end

   // Byte write into the shadow; bits beyond TOTAL_BITS in the last byte are dropped
   always_comb begin
      shadow_d = shadow_q;
      if (wr_en) begin
         for (int b = 0; b < TOTAL_BITS; b++) begin
            if (wr_idx == CNT_W'(b / 8)) begin
               shadow_d[b] = s_data[b % 8];
            end
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         data_q   <= '0;
         commit_q <= 1'b0;
         err_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         commit_q <= commit_d;
         err_q    <= err_d;
         rdy_q    <= rdy_d;
      end
   end

   assign pulse_en = (state_q == ST_FIRE);

   dreg_trig_pulse #(
      .TRIG_W (TRIG_W)
   ) u_trig_pulse (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .en     (pulse_en),
      .trig   (trig),
      .done   (pulse_done)
   );

   assign s_ready   = rdy_q;
   assign data_reg  = data_q;
   assign frame_err = err_q;
   assign committed = commit_q;

endmodule

// File: tb/tb_dreg_loader.sv
// Directed-sequence bench with randomized frame payloads; expected patterns
// come from packing the sent byte list arithmetically.
module tb_dreg_loader;
   import dreg_loader_pkg::*;

   localparam int TB = TOTAL_BITS_DFLT;
   localparam int NB = NBYTES_DFLT;
   localparam int TW = TRIG_W_DFLT;

   logic          clk_in = 1'b0;
   logic          rst_n;
   logic [7:0]    s_data;
   logic          s_valid;
   logic          s_sof;
   logic          s_ready;
   logic          auto_trig;
   logic          busy;
   logic [TB-1:0] data_reg;
   logic          trig;
   logic          frame_err;
   logic          committed;

   logic [7:0]    frame [NB];
   logic [TB-1:0] exp_data;
   logic [TB-1:0] old_data;
   int            checks = 0;
   int            errors = 0;
   int            nc, nt;

   always #5 clk_in = ~clk_in;

   dreg_loader #(
      .TOTAL_BITS (TB),
      .NBYTES     (NB),
      .TRIG_W     (TW)
   ) dut (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .s_data    (s_data),
      .s_valid   (s_valid),
      .s_sof     (s_sof),
      .s_ready   (s_ready),
      .auto_trig (auto_trig),
      .busy      (busy),
      .data_reg  (data_reg),
      .trig      (trig),
      .frame_err (frame_err),
      .committed (committed)
   );

   task automatic check(input string tag, input logic [TB-1:0] obs, input logic [TB-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // Little-endian byte packing; shifting past TB drops the unused top bits
   function automatic logic [TB-1:0] pack_frame();
      logic [TB-1:0] v;
      v = '0;
      for (int i = 0; i < NB; i++) v = v | (TB'(frame[i]) << (8 * i));
      return v;
   endfunction

   task automatic fill_frame(input logic [7:0] val, input bit rnd);
      for (int i = 0; i < NB; i++) frame[i] = rnd ? 8'($urandom) : val;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic sof);
      int n;
      n = 0;
      s_data  = d;
      s_sof   = sof;
      s_valid = 1'b1;
      while (s_ready !== 1'b1) begin
         if (n >= 300) begin
            checks++;
            errors++;
            $error("FAIL send_timeout observed=s_ready_low expected=s_ready_high");
            s_valid = 1'b0;
            return;
         end
         step();
         n++;
      end
      step();
      s_valid = 1'b0;
      s_sof   = 1'b0;
   endtask

   task automatic send_frame(input int nbytes, input bit gaps);
      for (int i = 0; i < nbytes; i++) begin
         send_byte(frame[i], i == 0);
         if (gaps && i < nbytes - 1) repeat ($urandom_range(0, 2)) step();
      end
   endtask

   task automatic observe(input int n, output int ncom, output int ntrig);
      ncom  = 0;
      ntrig = 0;
      repeat (n) begin
         step();
         if (committed) ncom++;
         if (trig) ntrig++;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
      busy = 1'b0; auto_trig = 1'b0;
      repeat (3) step();
      check("rst_ready", s_ready, 0);
      check("rst_data", data_reg, 0);
      check("rst_trig", trig, 0);
      check("rst_committed", committed, 0);
      check("rst_err", frame_err, 0);
      rst_n = 1'b1;
      step();
      check("rel_ready", s_ready, 1);

      // Full 0xA5 frame with auto trigger, exact latency
      auto_trig = 1'b1;
      fill_frame(8'hA5, 1'b0);
      exp_data = pack_frame();
      send_frame(NB, 1'b0);
      check("a5_pre_commit", data_reg, 0);
      step();
      check("a5_data", data_reg, exp_data);
      check("a5_low", data_reg[TB-3:0], {78{8'hA5}});
      check("a5_top", data_reg[TB-1:TB-2], 2'b01);
      check("a5_committed", committed, 1);
      check("a5_trig_early", trig, 0);
      check("a5_ready_commit", s_ready, 0);
      step();
      check("a5_trig_rise", trig, 1);
      check("a5_commit_once", committed, 0);
      observe(10, nc, nt);
      check("a5_trig_width", nt + 1, TW);
      check("a5_extra_commit", nc, 0);
      check("a5_ready_after", s_ready, 1);
      check("a5_err", frame_err, 0);

      // Random frame with gaps, no auto trigger
      auto_trig = 1'b0;
      fill_frame(8'h00, 1'b1);
      exp_data = pack_frame();
      send_frame(NB, 1'b1);
      observe(8, nc, nt);
      check("noauto_data", data_reg, exp_data);
      check("noauto_commits", nc, 1);
      check("noauto_trig", nt, 0);

      // Frame loaded while the serializer is busy
      old_data = exp_data;
      busy = 1'b1;
      auto_trig = 1'b1;
      fill_frame(8'h00, 1'b1);
      exp_data = pack_frame();
      send_frame(NB, 1'b1);
      for (int i = 0; i < 50; i++) begin
         step();
         check("hold_ready", s_ready, 0);
         check("hold_data", data_reg, old_data);
         check("hold_commit", committed, 0);
      end
      busy = 1'b0;
      step();
      check("busy_release_data", data_reg, exp_data);
      check("busy_release_commit", committed, 1);
      step();
      check("busy_trig_rise", trig, 1);
      busy = 1'b1;
      observe(10, nc, nt);
      check("busy_during_fire_width", nt + 1, TW);
      check("busy_during_fire_data", data_reg, exp_data);
      busy = 1'b0;

      // Restart: second sof arrives as byte 40 of a partial frame
      auto_trig = 1'b0;
      check("pre_restart_err", frame_err, 0);
      fill_frame(8'h00, 1'b1);
      send_frame(40, 1'b1);
      fill_frame(8'h00, 1'b1);
      exp_data = pack_frame();
      send_frame(NB, 1'b1);
      observe(8, nc, nt);
      check("restart_data", data_reg, exp_data);
      check("restart_commits", nc, 1);
      check("restart_err", frame_err, 1);

      // Reset clears the sticky error and data
      rst_n = 1'b0;
      step();
      check("rst2_err", frame_err, 0);
      check("rst2_data", data_reg, 0);
      check("rst2_ready", s_ready, 0);
      rst_n = 1'b1;
      step();

      // Stray byte in IDLE, then a clean frame must land aligned
      send_byte(8'($urandom), 1'b0);
      step();
      check("stray_err", frame_err, 1);
      check("stray_data", data_reg, 0);
      fill_frame(8'h00, 1'b1);
      exp_data = pack_frame();
      send_frame(NB, 1'b1);
      observe(8, nc, nt);
      check("after_stray_data", data_reg, exp_data);
      check("after_stray_commits", nc, 1);

      // Reset mid-frame returns to IDLE
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      fill_frame(8'h00, 1'b1);
      send_frame(30, 1'b1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      send_byte(8'h3C, 1'b0);
      step();
      check("midframe_idle_err", frame_err, 1);
      check("midframe_data", data_reg, 0);

      // Reset on the second trig cycle
      auto_trig = 1'b1;
      fill_frame(8'h00, 1'b1);
      exp_data = pack_frame();
      send_frame(NB, 1'b1);
      step();
      check("fire_rst_commit_data", data_reg, exp_data);
      step();
      check("fire_rst_trig1", trig, 1);
      step();
      check("fire_rst_trig2", trig, 1);
      rst_n = 1'b0;
      step();
      check("fire_rst_trig", trig, 0);
      check("fire_rst_data", data_reg, 0);
      check("fire_rst_ready", s_ready, 0);
      check("fire_rst_err", frame_err, 0);
      rst_n = 1'b1;
      step();
      check("fire_rel_ready", s_ready, 1);
      check("fire_rel_trig", trig, 0);
      send_byte(8'h81, 1'b0);
      step();
      check("fire_rel_idle", frame_err, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
